// File: rtl/systolic_feeder3x3.sv
// Edge feeder for the 3x3 output-stationary systolic array.
// Holds A and B, then streams them with diagonal skew plus drain cycles.
module systolic_feeder3x3 #(
    parameter int DW    = 32,
    parameter int DRAIN = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LD_VALID,
    output logic          LD_READY,
    input  logic          LD_SEL,
    input  logic [1:0]    LD_ROW,
    input  logic [1:0]    LD_COL,
    input  logic [DW-1:0] LD_DATA,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] A0,
    output logic [DW-1:0] A3,
    output logic [DW-1:0] A6,
    output logic [DW-1:0] B0,
    output logic [DW-1:0] B1,
    output logic [DW-1:0] B2,
    output logic          EN
);

    localparam int LAST = 4 + DRAIN;
    localparam int TW   = $clog2(LAST + 1);
    localparam logic [TW-1:0] LAST_T = TW'(LAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [DW-1:0] a_q [3][3];
    logic [DW-1:0] a_d [3][3];
    logic [DW-1:0] b_q [3][3];
    logic [DW-1:0] b_d [3][3];
    logic [DW-1:0] ao_q [3];
    logic [DW-1:0] ao_d [3];
    logic [DW-1:0] bo_q [3];
    logic [DW-1:0] bo_d [3];
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          emit;
    logic          wr;
    int            step_s;

    // Loads are only taken in IDLE and never on the cycle START is raised.
    always_comb begin
        LD_READY = (state_q == S_IDLE) && !START;
    end

    // Matrix write port; row or column 3 handshakes but is discarded.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        wr  = LD_VALID && LD_READY &&
              (LD_ROW != 2'd3) && (LD_COL != 2'd3);
        if (wr) begin
            if (LD_SEL) b_d[LD_ROW][LD_COL] = LD_DATA;
            else        a_d[LD_ROW][LD_COL] = LD_DATA;
        end
    end

    // Sequencer: picks the step shown next cycle and its skewed edge data.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        emit    = 1'b0;
        step_s  = 0;
        for (int i = 0; i < 3; i++) begin
            ao_d[i] = '0;
            bo_d[i] = '0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                    emit    = 1'b1;
                    step_s  = 0;
                end
            end
            S_STREAM, S_DRAIN: begin
                if (t_q == LAST_T) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d     = t_q + TW'(1);
                    step_s  = int'(t_q) + 1;
                    emit    = 1'b1;
                    state_d = (step_s < 5) ? S_STREAM : S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
        if (emit) begin
            en_d   = 1'b1;
            busy_d = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (step_s - i >= 0 && step_s - i <= 2) begin
                    ao_d[i] = a_q[i[1:0]][2'(step_s - i)];
                    bo_d[i] = b_q[2'(step_s - i)][i[1:0]];
                end
            end
        end
    end

    // State, storage and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            ao_q    <= '{default: '0};
            bo_q    <= '{default: '0};
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ao_q    <= ao_d;
            bo_q    <= bo_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A0   = ao_q[0];
    assign A3   = ao_q[1];
    assign A6   = ao_q[2];
    assign B0   = bo_q[0];
    assign B1   = bo_q[1];
    assign B2   = bo_q[2];
    assign EN   = en_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
